a_input_conditioner: RTL and testbench

- Upstream stage for the `top` pipecleaner core. It conditions the asynchronous, possibly bouncy primary input into a clean level plus single-cycle edge pulses in the `clk` domain.
- Output `a_clean` drives `top.a` directly.
- Also keeps a saturating count of rejected glitches, so PnR/gate-level runs can observe filter activity.

---
 rtl/a_input_conditioner.sv | 142 ++++++++++++++
 tb/tb_a_input_conditioner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_input_conditioner.sv
// Input conditioner: synchronizes and debounces a_raw into a clean level,
// with one-cycle rise/fall pulses and a saturating glitch counter.
module a_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_raw,
  output logic                a_clean,
  output logic                a_rise,
  output logic                a_fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] G_ONE = GLITCH_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;
  logic                   glitch_inc;

  // Pure flop chain; bit 0 is the metastability-catching stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], a_raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clean_d    = clean_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_d   = glitch_q;
    glitch_inc = 1'b0;

    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d    = STABLE_LO;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d    = STABLE_HI;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        clean_d = 1'b0;
      end
    endcase

    // Saturate instead of wrapping.
    if (glitch_inc && !(&glitch_q)) begin
      glitch_d = glitch_q + G_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign a_clean    = clean_q;
  assign a_rise     = rise_q;
  assign a_fall     = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_a_input_conditioner.sv
// Bench for a_input_conditioner: three parameterizations share one
// random/directed a_raw stream; a run-length model feeds a scoreboard.
module tb_a_input_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_raw = 1'b1;
  logic [2:0] cl, ri, fa;
  logic [7:0] g0, g2;
  logic [1:0] g1;

  always #5 clk = ~clk;

  a_input_conditioner d0 (
    .clk(clk), .reset(reset), .a_raw(a_raw),
    .a_clean(cl[0]), .a_rise(ri[0]), .a_fall(fa[0]),
    .glitch_cnt(g0)
  );

  a_input_conditioner #(.GLITCH_W(2)) d1 (
    .clk(clk), .reset(reset), .a_raw(a_raw),
    .a_clean(cl[1]), .a_rise(ri[1]), .a_fall(fa[1]),
    .glitch_cnt(g1)
  );

  a_input_conditioner #(
    .SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)
  ) d2 (
    .clk(clk), .reset(reset), .a_raw(a_raw),
    .a_clean(cl[2]), .a_rise(ri[2]), .a_fall(fa[2]),
    .glitch_cnt(g2)
  );

  typedef struct packed {
    logic [2:0]      clean;
    logic [2:0]      rise;
    logic [2:0]      fall;
    logic [2:0][7:0] gc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  int SS[3] = '{2, 2, 3};
  int DB[3] = '{4, 4, 2};
  int GM[3] = '{255, 3, 255};

  // Reference: a_clean flips once s has disagreed with it for DB
  // consecutive samples; a disagreeing run that ends early is a glitch.
  logic [7:0] rh;
  int         run[3];
  logic       m_clean[3];
  int         m_gc[3];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    rh = '0;
    for (int i = 0; i < 3; i++) begin
      run[i]     = 0;
      m_clean[i] = 1'b0;
      m_gc[i]    = 0;
    end
  endtask

  task automatic m_step();
    exp_t e;
    logic s;
    e  = '0;
    rh = {rh[6:0], a_raw};
    for (int i = 0; i < 3; i++) begin
      s = rh[SS[i]];
      if (s != m_clean[i]) begin
        run[i]++;
        if (run[i] == DB[i]) begin
          m_clean[i] = s;
          e.rise[i]  = s;
          e.fall[i]  = !s;
          run[i]     = 0;
        end
      end else begin
        if (run[i] != 0 && m_gc[i] < GM[i]) m_gc[i]++;
        run[i] = 0;
      end
      e.clean[i] = m_clean[i];
      e.gc[i]    = 8'(m_gc[i]);
    end
    sbq.push_back(e);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else m_step();
    end
  end

  // Monitor: outputs are registered, so one result per clock.
  initial begin
    exp_t e;
    logic [2:0][7:0] ga;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e     = sbq.pop_front();
        ga[0] = g0;
        ga[1] = {6'b0, g1};
        ga[2] = g2;
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("sb_clean%0d", i), cl[i], e.clean[i]);
          chk($sformatf("sb_rise%0d", i), ri[i], e.rise[i]);
          chk($sformatf("sb_fall%0d", i), fa[i], e.fall[i]);
          chk($sformatf("sb_gc%0d", i), ga[i], e.gc[i]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic v);
    @(negedge clk);
    reset = 1'b0;
    a_raw = v;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse(input int hi, input int lo);
    a_raw = 1'b1;
    repeat (hi) @(negedge clk);
    a_raw = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  int nr, nf;

  initial begin
    // 1: reset with a_raw=1, rise on edge 6 after release
    repeat (2) @(negedge clk);
    chk("t1_rst_outs", {cl, ri, fa}, 0);
    chk("t1_rst_gc", {g0, g1, g2}, 0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("t1_e5_clean", cl[0], 0);
    @(posedge clk);
    #1 chk("t1_e6_clean", cl[0], 1);
    chk("t1_e6_rise", ri[0], 1);
    @(posedge clk);
    #1 chk("t1_e7_rise", ri[0], 0);
    chk("t1_gc", g0, 0);

    // 2: toggle every 10 cycles, 9 toggles
    do_reset(1'b0);
    nr = 0;
    nf = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      nr += int'(ri[0]);
      nf += int'(fa[0]);
      if (t % 10 == 0 && t < 90) a_raw = ~a_raw;
    end
    chk("t2_rises", nr, 5);
    chk("t2_falls", nf, 4);
    chk("t2_clean", cl[0], 1);
    chk("t2_gc", g0, 0);

    // 3: 3-cycle glitch rejected, 4-cycle pulse accepted
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    nr = 0;
    a_raw = 1'b1;
    for (int t = 0; t < 15; t++) begin
      if (t == 3) a_raw = 1'b0;
      @(negedge clk);
      nr += int'(ri[0]);
    end
    chk("t3_glitch_gc", g0, 1);
    chk("t3_glitch_clean", cl[0], 0);
    chk("t3_glitch_rise", nr, 0);
    nr = 0;
    a_raw = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t == 4) a_raw = 1'b0;
      @(negedge clk);
      nr += int'(ri[0]);
    end
    chk("t3_accept_rise", nr, 1);
    chk("t3_accept_gc", g0, 1);

    // 4: saturation of the 2-bit counter
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      pulse(3, 8);
      chk($sformatf("t4_sat%0d", k), g1, (k < 3) ? k + 1 : 3);
    end

    // 5: async reset while in CHK_HI at cnt=2
    do_reset(1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("t5_async_outs", {cl, ri, fa}, 0);
    chk("t5_async_gc", {g0, g1, g2}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("t5_e5_clean", cl[0], 0);
    @(posedge clk);
    #1 chk("t5_e6_rise", ri[0], 1);
    chk("t5_gc", g0, 0);

    // 6: d2 latency (SYNC 3, DEB 2): clean on edge 5
    do_reset(1'b1);
    repeat (4) @(posedge clk);
    #1 chk("t6_e4_clean", cl[2], 0);
    @(posedge clk);
    #1 chk("t6_e5_clean", cl[2], 1);
    chk("t6_e5_rise", ri[2], 1);
    @(negedge clk);
    a_raw = 1'b0;
    repeat (8) @(negedge clk);
    // 1-cycle pulse on d2 is a glitch
    chk("t6_gc_before", g2, 0);
    pulse(1, 8);
    chk("t6_gc_after", g2, 1);

    // Random soak with occasional async reset pulses
    for (int n = 0; n < 400; n++) begin
      a_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 9)) @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
